// File: rtl/axi_arbiter_n.sv
// N-manager to 1-subordinate AXI4 arbiter: one transaction in flight at a time,
// round-robin or fixed-priority selection, with the manager index prepended to IDs.
module axi_arbiter_n #(
    parameter int NUM_MGR      = 3,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int ID_W         = 4,
    parameter int MODE         = 0,
    parameter int STARVE_LIMIT = 4,
    localparam int MGR_W  = (NUM_MGR > 2) ? $clog2(NUM_MGR) : 1,
    localparam int SID_W  = ID_W + MGR_W,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic                      clk_i,
    input  logic                      nrst_i,
    input  logic [NUM_MGR-1:0]        m_arvalid_i,
    output logic [NUM_MGR-1:0]        m_arready_o,
    input  logic [NUM_MGR*ADDR_W-1:0] m_araddr_i,
    input  logic [NUM_MGR*ID_W-1:0]   m_arid_i,
    input  logic [NUM_MGR*8-1:0]      m_arlen_i,
    output logic [NUM_MGR-1:0]        m_rvalid_o,
    input  logic [NUM_MGR-1:0]        m_rready_i,
    output logic [DATA_W-1:0]         m_rdata_o,
    output logic [ID_W-1:0]           m_rid_o,
    output logic [1:0]                m_rresp_o,
    output logic                      m_rlast_o,
    input  logic [NUM_MGR-1:0]        m_awvalid_i,
    output logic [NUM_MGR-1:0]        m_awready_o,
    input  logic [NUM_MGR*ADDR_W-1:0] m_awaddr_i,
    input  logic [NUM_MGR*ID_W-1:0]   m_awid_i,
    input  logic [NUM_MGR*8-1:0]      m_awlen_i,
    input  logic [NUM_MGR-1:0]        m_wvalid_i,
    output logic [NUM_MGR-1:0]        m_wready_o,
    input  logic [NUM_MGR*DATA_W-1:0] m_wdata_i,
    input  logic [NUM_MGR*STRB_W-1:0] m_wstrb_i,
    input  logic [NUM_MGR-1:0]        m_wlast_i,
    output logic [NUM_MGR-1:0]        m_bvalid_o,
    input  logic [NUM_MGR-1:0]        m_bready_i,
    output logic [ID_W-1:0]           m_bid_o,
    output logic [1:0]                m_bresp_o,
    output logic                      s_arvalid_o,
    input  logic                      s_arready_i,
    output logic [ADDR_W-1:0]         s_araddr_o,
    output logic [SID_W-1:0]          s_arid_o,
    output logic [7:0]                s_arlen_o,
    input  logic                      s_rvalid_i,
    output logic                      s_rready_o,
    input  logic [DATA_W-1:0]         s_rdata_i,
    input  logic [SID_W-1:0]          s_rid_i,
    input  logic [1:0]                s_rresp_i,
    input  logic                      s_rlast_i,
    output logic                      s_awvalid_o,
    input  logic                      s_awready_i,
    output logic [ADDR_W-1:0]         s_awaddr_o,
    output logic [SID_W-1:0]          s_awid_o,
    output logic [7:0]                s_awlen_o,
    output logic                      s_wvalid_o,
    input  logic                      s_wready_i,
    output logic [DATA_W-1:0]         s_wdata_o,
    output logic [STRB_W-1:0]         s_wstrb_o,
    output logic                      s_wlast_o,
    input  logic                      s_bvalid_i,
    output logic                      s_bready_o,
    input  logic [SID_W-1:0]          s_bid_i,
    input  logic [1:0]                s_bresp_i,
    output logic [NUM_MGR-1:0]        grant_o,
    output logic                      busy_o
);

    typedef enum logic [2:0] {IDLE, RADDR, RDATA, WADDR, WDATA, WRESP} state_e;

    localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    state_e             state_q, state_d;
    logic [MGR_W-1:0]   gidx_q, gidx_d, ptr_q, ptr_d, win;
    logic [CNT_W-1:0]   starve_q [NUM_MGR];
    logic [CNT_W-1:0]   starve_d [NUM_MGR];
    logic [NUM_MGR-1:0] req, gsel;
    logic               found;

    assign req     = m_arvalid_i | m_awvalid_i;
    assign gsel    = NUM_MGR'(1) << gidx_q;
    assign grant_o = (state_q == IDLE) ? '0 : gsel;
    assign busy_o  = (state_q != IDLE);

    // A starved manager only wins while it is still requesting.
    always_comb begin
        found = 1'b0;
        win   = '0;
        if (MODE == 0) begin
            for (int k = 1; k <= NUM_MGR; k++) begin
                if (!found && req[(int'(ptr_q) + k) % NUM_MGR]) begin
                    found = 1'b1;
                    win   = MGR_W'((int'(ptr_q) + k) % NUM_MGR);
                end
            end
        end else begin
            for (int i = 0; i < NUM_MGR; i++) begin
                if (!found && req[i] && starve_q[i] == LIMIT) begin
                    found = 1'b1;
                    win   = MGR_W'(i);
                end
            end
            for (int i = 0; i < NUM_MGR; i++) begin
                if (!found && req[i]) begin
                    found = 1'b1;
                    win   = MGR_W'(i);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_q <= IDLE;
            gidx_q  <= '0;
            ptr_q   <= MGR_W'(NUM_MGR - 1);
            for (int i = 0; i < NUM_MGR; i++) starve_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            gidx_q   <= gidx_d;
            ptr_q    <= ptr_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        gidx_d   = gidx_q;
        ptr_d    = ptr_q;
        starve_d = starve_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    gidx_d  = win;
                    state_d = m_arvalid_i[win] ? RADDR : WADDR;
                    if (MODE == 0) begin
                        ptr_d = win;
                    end else begin
                        for (int i = 0; i < NUM_MGR; i++) begin
                            if (MGR_W'(i) == win)
                                starve_d[i] = '0;
                            else if (req[i] && starve_q[i] != LIMIT)
                                starve_d[i] = starve_q[i] + 1'b1;
                        end
                    end
                end
            end
            RADDR: if (m_arvalid_i[gidx_q] && s_arready_i) state_d = RDATA;
            RDATA: if (s_rvalid_i && m_rready_i[gidx_q] && s_rlast_i) state_d = IDLE;
            WADDR: if (m_awvalid_i[gidx_q] && s_awready_i) state_d = WDATA;
            WDATA: if (m_wvalid_i[gidx_q] && s_wready_i && m_wlast_i[gidx_q]) state_d = WRESP;
            WRESP: if (s_bvalid_i && m_bready_i[gidx_q]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Routing follows the latched grantee; the index field of s_rid/s_bid is not consulted.
    always_comb begin
        m_arready_o = '0;
        m_rvalid_o  = '0;
        m_rdata_o   = '0;
        m_rid_o     = '0;
        m_rresp_o   = '0;
        m_rlast_o   = 1'b0;
        m_awready_o = '0;
        m_wready_o  = '0;
        m_bvalid_o  = '0;
        m_bid_o     = '0;
        m_bresp_o   = '0;
        s_arvalid_o = 1'b0;
        s_araddr_o  = '0;
        s_arid_o    = '0;
        s_arlen_o   = '0;
        s_rready_o  = 1'b0;
        s_awvalid_o = 1'b0;
        s_awaddr_o  = '0;
        s_awid_o    = '0;
        s_awlen_o   = '0;
        s_wvalid_o  = 1'b0;
        s_wdata_o   = '0;
        s_wstrb_o   = '0;
        s_wlast_o   = 1'b0;
        s_bready_o  = 1'b0;
        case (state_q)
            RADDR: begin
                s_arvalid_o = m_arvalid_i[gidx_q];
                s_araddr_o  = m_araddr_i[gidx_q*ADDR_W +: ADDR_W];
                s_arid_o    = {gidx_q, m_arid_i[gidx_q*ID_W +: ID_W]};
                s_arlen_o   = m_arlen_i[gidx_q*8 +: 8];
                m_arready_o = gsel & {NUM_MGR{s_arready_i}};
            end
            RDATA: begin
                m_rvalid_o = gsel & {NUM_MGR{s_rvalid_i}};
                s_rready_o = m_rready_i[gidx_q];
                m_rdata_o  = s_rdata_i;
                m_rid_o    = s_rid_i[ID_W-1:0];
                m_rresp_o  = s_rresp_i;
                m_rlast_o  = s_rlast_i;
            end
            WADDR: begin
                s_awvalid_o = m_awvalid_i[gidx_q];
                s_awaddr_o  = m_awaddr_i[gidx_q*ADDR_W +: ADDR_W];
                s_awid_o    = {gidx_q, m_awid_i[gidx_q*ID_W +: ID_W]};
                s_awlen_o   = m_awlen_i[gidx_q*8 +: 8];
                m_awready_o = gsel & {NUM_MGR{s_awready_i}};
            end
            WDATA: begin
                s_wvalid_o = m_wvalid_i[gidx_q];
                s_wdata_o  = m_wdata_i[gidx_q*DATA_W +: DATA_W];
                s_wstrb_o  = m_wstrb_i[gidx_q*STRB_W +: STRB_W];
                s_wlast_o  = m_wlast_i[gidx_q];
                m_wready_o = gsel & {NUM_MGR{s_wready_i}};
            end
            WRESP: begin
                m_bvalid_o = gsel & {NUM_MGR{s_bvalid_i}};
                s_bready_o = m_bready_i[gidx_q];
                m_bid_o    = s_bid_i[ID_W-1:0];
                m_bresp_o  = s_bresp_i;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi_arbiter_n.sv
// Directed bench for axi_arbiter_n: a round-robin instance driven by a scripted
// subordinate and a fixed-priority instance behind an always-ready subordinate.
module tb_axi_arbiter_n;
    localparam int N = 3, AW = 32, DW = 32, IW = 4, SW = 6;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]      m_arvalid, m_rready, m_awvalid, m_wvalid, m_wlast, m_bready;
    logic [N*AW-1:0]   m_araddr, m_awaddr;
    logic [N*IW-1:0]   m_arid, m_awid;
    logic [N*8-1:0]    m_arlen, m_awlen;
    logic [N*DW-1:0]   m_wdata;
    logic [N*DW/8-1:0] m_wstrb;
    logic              s_arready, s_rvalid, s_rlast, s_awready, s_wready, s_bvalid;
    logic [DW-1:0]     s_rdata;
    logic [SW-1:0]     s_rid, s_bid;
    logic [1:0]        s_rresp, s_bresp;

    logic [N-1:0]  rr_m_arready, rr_m_rvalid, rr_m_awready, rr_m_wready, rr_m_bvalid, rr_grant;
    logic [DW-1:0] rr_m_rdata, rr_s_wdata;
    logic [IW-1:0] rr_m_rid, rr_m_bid;
    logic [1:0]    rr_m_rresp, rr_m_bresp;
    logic          rr_m_rlast, rr_s_arvalid, rr_s_rready, rr_s_awvalid, rr_s_wvalid, rr_s_wlast;
    logic          rr_s_bready, rr_busy;
    logic [AW-1:0] rr_s_araddr, rr_s_awaddr;
    logic [SW-1:0] rr_s_arid, rr_s_awid;
    logic [7:0]    rr_s_arlen, rr_s_awlen;
    logic [DW/8-1:0] rr_s_wstrb;

    logic [N-1:0]  fp_m_arready, fp_m_rvalid, fp_m_awready, fp_m_wready, fp_m_bvalid, fp_grant;
    logic [DW-1:0] fp_m_rdata, fp_s_wdata;
    logic [IW-1:0] fp_m_rid, fp_m_bid;
    logic [1:0]    fp_m_rresp, fp_m_bresp;
    logic          fp_m_rlast, fp_s_arvalid, fp_s_rready, fp_s_awvalid, fp_s_wvalid, fp_s_wlast;
    logic          fp_s_bready, fp_busy;
    logic [AW-1:0] fp_s_araddr, fp_s_awaddr;
    logic [SW-1:0] fp_s_arid, fp_s_awid;
    logic [7:0]    fp_s_arlen, fp_s_awlen;
    logic [DW/8-1:0] fp_s_wstrb;

    int n_cmp = 0;
    int n_bad = 0;

    axi_arbiter_n #(.NUM_MGR(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .MODE(0)) u_rr (
        .clk_i(clk), .nrst_i(nrst),
        .m_arvalid_i(m_arvalid), .m_arready_o(rr_m_arready), .m_araddr_i(m_araddr),
        .m_arid_i(m_arid), .m_arlen_i(m_arlen),
        .m_rvalid_o(rr_m_rvalid), .m_rready_i(m_rready), .m_rdata_o(rr_m_rdata),
        .m_rid_o(rr_m_rid), .m_rresp_o(rr_m_rresp), .m_rlast_o(rr_m_rlast),
        .m_awvalid_i(m_awvalid), .m_awready_o(rr_m_awready), .m_awaddr_i(m_awaddr),
        .m_awid_i(m_awid), .m_awlen_i(m_awlen),
        .m_wvalid_i(m_wvalid), .m_wready_o(rr_m_wready), .m_wdata_i(m_wdata),
        .m_wstrb_i(m_wstrb), .m_wlast_i(m_wlast),
        .m_bvalid_o(rr_m_bvalid), .m_bready_i(m_bready), .m_bid_o(rr_m_bid), .m_bresp_o(rr_m_bresp),
        .s_arvalid_o(rr_s_arvalid), .s_arready_i(s_arready), .s_araddr_o(rr_s_araddr),
        .s_arid_o(rr_s_arid), .s_arlen_o(rr_s_arlen),
        .s_rvalid_i(s_rvalid), .s_rready_o(rr_s_rready), .s_rdata_i(s_rdata),
        .s_rid_i(s_rid), .s_rresp_i(s_rresp), .s_rlast_i(s_rlast),
        .s_awvalid_o(rr_s_awvalid), .s_awready_i(s_awready), .s_awaddr_o(rr_s_awaddr),
        .s_awid_o(rr_s_awid), .s_awlen_o(rr_s_awlen),
        .s_wvalid_o(rr_s_wvalid), .s_wready_i(s_wready), .s_wdata_o(rr_s_wdata),
        .s_wstrb_o(rr_s_wstrb), .s_wlast_o(rr_s_wlast),
        .s_bvalid_i(s_bvalid), .s_bready_o(rr_s_bready), .s_bid_i(s_bid), .s_bresp_i(s_bresp),
        .grant_o(rr_grant), .busy_o(rr_busy)
    );

    axi_arbiter_n #(.NUM_MGR(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .MODE(1),
                    .STARVE_LIMIT(2)) u_fp (
        .clk_i(clk), .nrst_i(nrst),
        .m_arvalid_i(m_arvalid), .m_arready_o(fp_m_arready), .m_araddr_i(m_araddr),
        .m_arid_i(m_arid), .m_arlen_i(m_arlen),
        .m_rvalid_o(fp_m_rvalid), .m_rready_i(m_rready), .m_rdata_o(fp_m_rdata),
        .m_rid_o(fp_m_rid), .m_rresp_o(fp_m_rresp), .m_rlast_o(fp_m_rlast),
        .m_awvalid_i(m_awvalid), .m_awready_o(fp_m_awready), .m_awaddr_i(m_awaddr),
        .m_awid_i(m_awid), .m_awlen_i(m_awlen),
        .m_wvalid_i(m_wvalid), .m_wready_o(fp_m_wready), .m_wdata_i(m_wdata),
        .m_wstrb_i(m_wstrb), .m_wlast_i(m_wlast),
        .m_bvalid_o(fp_m_bvalid), .m_bready_i(m_bready), .m_bid_o(fp_m_bid), .m_bresp_o(fp_m_bresp),
        .s_arvalid_o(fp_s_arvalid), .s_arready_i(1'b1), .s_araddr_o(fp_s_araddr),
        .s_arid_o(fp_s_arid), .s_arlen_o(fp_s_arlen),
        .s_rvalid_i(1'b1), .s_rready_o(fp_s_rready), .s_rdata_i(32'h0),
        .s_rid_i(6'h0), .s_rresp_i(2'b00), .s_rlast_i(1'b1),
        .s_awvalid_o(fp_s_awvalid), .s_awready_i(1'b1), .s_awaddr_o(fp_s_awaddr),
        .s_awid_o(fp_s_awid), .s_awlen_o(fp_s_awlen),
        .s_wvalid_o(fp_s_wvalid), .s_wready_i(1'b1), .s_wdata_o(fp_s_wdata),
        .s_wstrb_o(fp_s_wstrb), .s_wlast_o(fp_s_wlast),
        .s_bvalid_i(1'b1), .s_bready_o(fp_s_bready), .s_bid_i(6'h0), .s_bresp_i(2'b00),
        .grant_o(fp_grant), .busy_o(fp_busy)
    );

    task automatic do_reset();
        nrst = 1'b0;
        m_arvalid = '0; m_awvalid = '0; m_wvalid = '0; m_wlast = '0;
        m_rready = '1;  m_bready = '1;
        m_araddr = '0;  m_awaddr = '0; m_arid = '0; m_awid = '0;
        m_arlen = '0;   m_awlen = '0;  m_wdata = '0; m_wstrb = '0;
        s_arready = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0; s_awready = 1'b0;
        s_wready = 1'b0;  s_bvalid = 1'b0; s_rdata = '0; s_rid = '0; s_bid = '0;
        s_rresp = '0; s_bresp = '0;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
    endtask

    task automatic sub_auto();
        s_arready = 1'b1; s_rvalid = 1'b1; s_rlast = 1'b1;
        s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_cmp++; if (rr_grant !== 3'b000) begin n_bad++; $display("FAIL reset_grant: got %b want 000", rr_grant); end
        n_cmp++; if (rr_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", rr_busy); end
        n_cmp++; if ({rr_m_arready, rr_m_awready, rr_m_wready, rr_m_rvalid, rr_m_bvalid} !== 15'h0) begin
            n_bad++; $display("FAIL reset_mgr_handshakes: got %h want 0",
                {rr_m_arready, rr_m_awready, rr_m_wready, rr_m_rvalid, rr_m_bvalid}); end
        n_cmp++; if ({rr_s_arvalid, rr_s_awvalid, rr_s_wvalid, rr_s_rready, rr_s_bready} !== 5'h0) begin
            n_bad++; $display("FAIL reset_sub_handshakes: got %b want 00000",
                {rr_s_arvalid, rr_s_awvalid, rr_s_wvalid, rr_s_rready, rr_s_bready}); end
        n_cmp++; if (rr_s_araddr !== 32'h0) begin n_bad++; $display("FAIL idle_araddr: got %h want 0", rr_s_araddr); end
        m_araddr[AW +: AW] = 32'h0000_1000;
        m_arvalid = 3'b010;
        #1;
        n_cmp++; if (rr_grant !== 3'b000 || rr_m_arready !== 3'b000) begin
            n_bad++; $display("FAIL idle_no_grant: got grant %b arready %b want 000 000", rr_grant, rr_m_arready); end
        @(negedge clk);
        n_cmp++; if (rr_grant !== 3'b010 || rr_busy !== 1'b1) begin
            n_bad++; $display("FAIL arb_latency: got grant %b busy %b want 010 1", rr_grant, rr_busy); end
        n_cmp++; if (rr_s_arvalid !== 1'b1 || rr_s_araddr !== 32'h0000_1000 || rr_s_arid !== 6'h10) begin
            n_bad++; $display("FAIL raddr_fwd: got v %b addr %h id %h want 1 00001000 10",
                rr_s_arvalid, rr_s_araddr, rr_s_arid); end
        n_cmp++; if (rr_m_arready !== 3'b000) begin n_bad++; $display("FAIL arready_stall: got %b want 000", rr_m_arready); end
    endtask

    task automatic test_rr_all3();
        int k, last;
        logic [N-1:0] clr;
        int rv_cnt [N];
        do_reset();
        sub_auto();
        m_arid = {4'h3, 4'h2, 4'h1};
        m_araddr = {32'h300, 32'h200, 32'h100};
        m_arvalid = 3'b111;
        k = 0; last = -1; clr = '0;
        for (int i = 0; i < N; i++) rv_cnt[i] = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            m_arvalid = m_arvalid & ~clr;
            clr = '0;
            #1;
            if (rr_m_rvalid !== 3'b000) begin
                n_cmp++;
                if (last < 0 || rr_m_rvalid !== 3'(1 << last)) begin
                    n_bad++; $display("FAIL rr3_rvalid_route: got %b want onehot of %0d", rr_m_rvalid, last); end
                for (int i = 0; i < N; i++) if (rr_m_rvalid[i]) rv_cnt[i]++;
            end
            if (rr_s_arvalid === 1'b1 && k < 3) begin
                n_cmp++; if (rr_grant !== 3'(1 << k)) begin
                    n_bad++; $display("FAIL rr3_grant[%0d]: got %b want %b", k, rr_grant, 3'(1 << k)); end
                n_cmp++; if (rr_s_arid !== {2'(k), 4'(k + 1)} || rr_s_araddr !== 32'(32'h100 * (k + 1))) begin
                    n_bad++; $display("FAIL rr3_arid[%0d]: got id %h addr %h want %h %h", k, rr_s_arid,
                        rr_s_araddr, {2'(k), 4'(k + 1)}, 32'(32'h100 * (k + 1))); end
                clr = 3'(1 << k);
                last = k;
                k++;
            end
        end
        n_cmp++; if (k != 3) begin n_bad++; $display("FAIL rr3_grant_count: got %0d want 3", k); end
        for (int i = 0; i < N; i++) begin
            n_cmp++; if (rv_cnt[i] != 1) begin n_bad++; $display("FAIL rr3_rvalid_pulses[%0d]: got %0d want 1", i, rv_cnt[i]); end
        end
    endtask

    task automatic test_rr_pair();
        logic [N-1:0] exp_g [4];
        logic [N-1:0] prev;
        int k;
        logic seen1;
        exp_g[0] = 3'b001; exp_g[1] = 3'b100; exp_g[2] = 3'b001; exp_g[3] = 3'b100;
        do_reset();
        sub_auto();
        m_arvalid = 3'b101;
        k = 0; prev = '0; seen1 = 1'b0;
        for (int cyc = 0; cyc < 40 && k < 4; cyc++) begin
            @(negedge clk);
            if (rr_grant !== 3'b000 && prev === 3'b000) begin
                n_cmp++; if (rr_grant !== exp_g[k]) begin
                    n_bad++; $display("FAIL rr_pair_grant[%0d]: got %b want %b", k, rr_grant, exp_g[k]); end
                k++;
            end
            if (rr_grant[1] === 1'b1) seen1 = 1'b1;
            prev = rr_grant;
        end
        n_cmp++; if (k != 4) begin n_bad++; $display("FAIL rr_pair_count: got %0d want 4", k); end
        n_cmp++; if (seen1 !== 1'b0) begin n_bad++; $display("FAIL rr_pair_idle_mgr: got granted want never"); end
    endtask

    task automatic test_priority();
        logic [N-1:0] exp_g [6];
        logic [N-1:0] prev;
        int k;
        exp_g[0] = 3'b001; exp_g[1] = 3'b001; exp_g[2] = 3'b010;
        exp_g[3] = 3'b001; exp_g[4] = 3'b001; exp_g[5] = 3'b010;
        do_reset();
        m_arvalid = 3'b011;
        k = 0; prev = '0;
        for (int cyc = 0; cyc < 60 && k < 6; cyc++) begin
            @(negedge clk);
            if (fp_grant !== 3'b000 && prev === 3'b000) begin
                n_cmp++; if (fp_grant !== exp_g[k]) begin
                    n_bad++; $display("FAIL prio_grant[%0d]: got %b want %b", k, fp_grant, exp_g[k]); end
                k++;
            end
            prev = fp_grant;
        end
        n_cmp++; if (k != 6) begin n_bad++; $display("FAIL prio_count: got %0d want 6", k); end
    endtask

    task automatic test_burst_read();
        logic got;
        do_reset();
        s_arready = 1'b1;
        m_arid[IW +: IW] = 4'hA;
        m_arlen[8 +: 8] = 8'd3;
        m_araddr[AW +: AW] = 32'h40;
        m_arvalid = 3'b010;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk); #1;
            if (rr_s_arvalid === 1'b1) got = 1'b1;
        end
        n_cmp++; if (!got) begin n_bad++; $display("FAIL burst_ar_timeout: got no s_arvalid want one"); end
        n_cmp++; if (rr_s_arlen !== 8'd3 || rr_s_arid !== 6'h1A || rr_s_araddr !== 32'h40) begin
            n_bad++; $display("FAIL burst_ar_fwd: got len %0d id %h addr %h want 3 1a 40",
                rr_s_arlen, rr_s_arid, rr_s_araddr); end
        @(negedge clk);
        m_arvalid = '0;
        for (int b = 0; b < 4; b++) begin
            s_rvalid = 1'b1;
            s_rdata = 32'hD000 + 32'(b);
            s_rid = (b == 2) ? 6'h3A : 6'h1A;
            s_rlast = (b == 3);
            #1;
            n_cmp++; if (rr_m_rvalid !== 3'b010 || rr_s_rready !== 1'b1) begin
                n_bad++; $display("FAIL burst_rvalid[%0d]: got %b rready %b want 010 1", b, rr_m_rvalid, rr_s_rready); end
            n_cmp++; if (rr_m_rid !== 4'hA || rr_m_rdata !== 32'hD000 + 32'(b) || rr_m_rlast !== (b == 3)) begin
                n_bad++; $display("FAIL burst_beat[%0d]: got id %h data %h last %b want a %h %b",
                    b, rr_m_rid, rr_m_rdata, rr_m_rlast, 32'hD000 + 32'(b), (b == 3)); end
            @(negedge clk);
        end
        s_rvalid = 1'b0; s_rlast = 1'b0;
        #1;
        n_cmp++; if (rr_busy !== 1'b0 || rr_m_rvalid !== 3'b000) begin
            n_bad++; $display("FAIL burst_end_idle: got busy %b rvalid %b want 0 000", rr_busy, rr_m_rvalid); end
    endtask

    task automatic test_write();
        logic got;
        do_reset();
        s_awready = 1'b1;
        m_awid[2*IW +: IW] = 4'h5;
        m_awlen[16 +: 8] = 8'd1;
        m_awaddr[2*AW +: AW] = 32'h80;
        m_awvalid = 3'b100;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk); #1;
            if (rr_s_awvalid === 1'b1) got = 1'b1;
        end
        n_cmp++; if (!got) begin n_bad++; $display("FAIL write_aw_timeout: got no s_awvalid want one"); end
        n_cmp++; if (rr_s_awid !== 6'h25 || rr_s_awlen !== 8'd1 || rr_s_awaddr !== 32'h80 ||
                     rr_m_awready !== 3'b100 || rr_m_wready !== 3'b000) begin
            n_bad++; $display("FAIL write_aw_fwd: got id %h len %0d addr %h awready %b wready %b want 25 1 80 100 000",
                rr_s_awid, rr_s_awlen, rr_s_awaddr, rr_m_awready, rr_m_wready); end
        @(negedge clk);
        m_awvalid = '0;
        s_wready = 1'b1;
        m_wvalid = 3'b100;
        for (int b = 0; b < 2; b++) begin
            m_wdata[2*DW +: DW] = 32'hBEEF_0000 + 32'(b);
            m_wstrb[8 +: 4] = 4'b0011;
            m_wlast = (b == 1) ? 3'b100 : 3'b000;
            #1;
            n_cmp++; if (rr_s_wvalid !== 1'b1 || rr_m_wready !== 3'b100 || rr_s_wdata !== 32'hBEEF_0000 + 32'(b) ||
                         rr_s_wstrb !== 4'b0011 || rr_s_wlast !== (b == 1)) begin
                n_bad++; $display("FAIL write_beat[%0d]: got v %b rdy %b data %h strb %b last %b", b,
                    rr_s_wvalid, rr_m_wready, rr_s_wdata, rr_s_wstrb, rr_s_wlast); end
            @(negedge clk);
        end
        s_bvalid = 1'b1; s_bid = 6'h25; s_bresp = 2'b10;
        #1;
        n_cmp++; if (rr_s_wvalid !== 1'b0 || rr_m_wready !== 3'b000) begin
            n_bad++; $display("FAIL write_extra_beat: got wvalid %b wready %b want 0 000", rr_s_wvalid, rr_m_wready); end
        n_cmp++; if (rr_m_bvalid !== 3'b100 || rr_m_bresp !== 2'b10 || rr_m_bid !== 4'h5 || rr_s_bready !== 1'b1) begin
            n_bad++; $display("FAIL write_bresp: got bvalid %b resp %b id %h bready %b want 100 10 5 1",
                rr_m_bvalid, rr_m_bresp, rr_m_bid, rr_s_bready); end
        @(negedge clk);
        m_wvalid = '0; m_wlast = '0; s_bvalid = 1'b0;
        #1;
        n_cmp++; if (rr_busy !== 1'b0) begin n_bad++; $display("FAIL write_end_idle: got busy %b want 0", rr_busy); end
    endtask

    task automatic test_reset_mid();
        logic got;
        do_reset();
        s_arready = 1'b1;
        m_arvalid = 3'b100;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk); #1;
            if (rr_s_arvalid === 1'b1) got = 1'b1;
        end
        n_cmp++; if (!got) begin n_bad++; $display("FAIL rstmid_ar_timeout: got no s_arvalid want one"); end
        @(negedge clk);
        m_arvalid = '0;
        s_rvalid = 1'b1; s_rlast = 1'b0; s_rid = 6'h20;
        #1;
        n_cmp++; if (rr_m_rvalid !== 3'b100) begin n_bad++; $display("FAIL rstmid_rdata: got %b want 100", rr_m_rvalid); end
        nrst = 1'b0;
        #1;
        n_cmp++; if (rr_grant !== 3'b000 || rr_busy !== 1'b0 || rr_m_rvalid !== 3'b000 ||
                     rr_s_rready !== 1'b0 || rr_m_arready !== 3'b000) begin
            n_bad++; $display("FAIL rstmid_outputs: got grant %b busy %b rvalid %b rready %b arready %b want all 0",
                rr_grant, rr_busy, rr_m_rvalid, rr_s_rready, rr_m_arready); end
        s_rvalid = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        m_arvalid = 3'b101;
        @(negedge clk);
        n_cmp++; if (rr_grant !== 3'b001) begin n_bad++; $display("FAIL rstmid_first_grant: got %b want 001", rr_grant); end
    endtask

    initial begin
        test_reset();
        test_rr_all3();
        test_rr_pair();
        test_priority();
        test_burst_read();
        test_write();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/axi_arbiter_n.md
Name: axi_arbiter_n

Overview:
- Parametrised N-manager to 1-subordinate AXI4 arbiter.
- Generalises the fixed three-manager (icache/dcache/dma) arbitration in front of a single subordinate port (sram/flash/dram/ahb).
- Adds selectable round-robin or fixed-priority arbitration, a starvation guard in priority mode, burst support, and manager-index tagging of IDs.
- One transaction (read or write) is in flight at a time; responses are routed back to the latched grantee.

Parameters:
NUM_MGR, 3, number of manager ports (2..8)
ADDR_W, 32, address width
DATA_W, 32, data width; strobe width = DATA_W/8
ID_W, 4, manager-side ID width; subordinate-side ID width SID_W = ID_W + MGR_W, where MGR_W = max(1, clog2(NUM_MGR))
MODE, 0, 0 = round robin; 1 = fixed priority (index 0 highest) with starvation guard
STARVE_LIMIT, 4, MODE=1 only: arbitration losses after which a waiting manager is forced to win

Ports:
clk  in  1  clock; all logic on posedge
nrst  in  1  asynchronous active-low reset
m_arvalid, m_arready  in/out  NUM_MGR  per-manager AR handshake
m_araddr, m_arid, m_arlen  in  NUM_MGR*ADDR_W / NUM_MGR*ID_W / NUM_MGR*8  packed AR payloads, manager i at slice i
m_rvalid, m_rready  out/in  NUM_MGR  per-manager R handshake
m_rdata, m_rid, m_rresp, m_rlast  out  DATA_W / ID_W / 2 / 1  shared R payload, meaningful only with the matching m_rvalid bit
m_awvalid, m_awready  in/out  NUM_MGR  per-manager AW handshake
m_awaddr, m_awid, m_awlen  in  packed as for AR  AW payloads
m_wvalid, m_wready  in/out  NUM_MGR  per-manager W handshake
m_wdata, m_wstrb, m_wlast  in  NUM_MGR*DATA_W / NUM_MGR*DATA_W/8 / NUM_MGR  W payloads
m_bvalid, m_bready  out/in  NUM_MGR  per-manager B handshake
m_bid, m_bresp  out  ID_W / 2  shared B payload
s_ar*, s_aw*, s_w*  out (ready in)  single-port versions; s_arid, s_awid are SID_W wide
s_r*, s_b*  in (ready out)  single-port versions; s_rid, s_bid are SID_W wide
grant  out  NUM_MGR  one-hot current owner; 0 in IDLE
busy  out  1  high in any state other than IDLE

Behaviour:
- States: IDLE, RADDR, RDATA, WADDR, WDATA, WRESP.
- Reset (nrst low, asynchronous):
  - State goes to IDLE.
  - All valid/ready outputs, grant and busy go to 0.
  - RR pointer resets to NUM_MGR-1, so manager 0 wins first.
  - Starvation counters reset to 0.
  - Applies mid-transaction as well; in-flight beats are dropped.
- Request of manager i: req[i] = m_arvalid[i] | m_awvalid[i]. If both are set, read is serviced first.
- IDLE:
  - If any req, the winner is latched at the posedge and the next state is RADDR or WADDR.
  - Arbitration latency is 1 cycle; no ready is asserted in IDLE.
- MODE=0: search starts at pointer+1 and wraps modulo NUM_MGR. On grant, pointer = winner.
- MODE=1:
  - Lowest-index requester wins, unless one or more counters have reached STARVE_LIMIT; then the lowest-index such manager wins.
  - Every requesting loser increments its counter, saturating at STARVE_LIMIT.
  - The winner's counter clears. Non-requesters' counters hold.
- RADDR:
  - s_ar* = grantee's AR payload; s_arid = {g, m_arid[g]}.
  - m_arready[g] = s_arready; all other m_arready = 0.
  - On s_arvalid & s_arready, go to RDATA.
- RDATA:
  - m_rvalid[g] = s_rvalid; s_rready = m_rready[g].
  - m_rid = s_rid[ID_W-1:0].
  - On a beat with rlast, go to IDLE.
  - An s_rid upper field not equal to g is ignored; routing is by the latched g.
- WADDR: AW forwarded as for AR. On handshake, go to WDATA. m_wready stays 0 in this state, which is legal AXI subordinate behaviour.
- WDATA: W beats forwarded to the grantee only. On the wlast handshake, go to WRESP.
- WRESP: B routed to g; m_bid = s_bid[ID_W-1:0]. On the B handshake, go to IDLE.
- All forwarding is combinational from the latched grant: zero added latency per beat.
- A request arriving at the IDLE->X edge waits for the next IDLE.
- Burst length comes from arlen/awlen and is passed through unchanged. Termination is by last only; the arbiter keeps no beat counter.
- Payload outputs are don't-care while the corresponding valid is 0, but are driven to 0 in IDLE.

Test Plan:
- MODE=0: after reset, all 3 managers issue single-beat reads at the same time -> grants 0, 1, 2 in order; s_arid[5:4] = 0, 1, 2; each m_rvalid pulses only on its own index.
- MODE=0: managers 0 and 2 request back-to-back continuously, manager 1 idle -> grant sequence 0, 2, 0, 2; manager 1 never granted.
- MODE=1, STARVE_LIMIT=2: managers 0 and 1 request continuously -> grant sequence 0, 0, 1, 0, 0, 1.
- Manager 1 read with arlen=3, arid=4'hA; subordinate returns 4 beats with rid={2'd1,4'hA} -> manager 1 sees 4 beats, m_rid=4'hA, m_rlast on beat 4; state returns to IDLE; other m_rvalid bits stay 0.
- Manager 2 write, awlen=1, wstrb=4'b0011; subordinate returns bresp=2'b10 -> exactly 2 W beats forwarded; m_bvalid[2] with m_bresp=2'b10 and m_bid equal to the original awid.
- nrst pulsed low during RDATA of manager 2 -> all outputs 0 within the same cycle; after release, a simultaneous request from managers 0 and 2 grants manager 0 first.
